cpu_acumulador_param: RTL and testbench

CPU_ACUMULADOR_PARAM -- requirements
Module: cpu_acumulador_param

---
 rtl/cpu_acumulador_param.sv | 216 +++++++++++++++++++++
 tb/tb_cpu_acumulador_param.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_acumulador_param.sv
// Parameterised accumulator CPU: multi-cycle FSM over a synchronous single-port memory,
// with a HALT-only program-load port and valid/ready input and output channels.
module cpu_acumulador_param #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [DATA_W-1:0] entrada,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] saida,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ac,
    output logic              flag_n,
    output logic              flag_z,
    output logic              halted,
    output logic [3:0]        estado
);

    typedef enum logic [3:0] {
        S_HALT    = 4'd0,
        S_F_ADDR  = 4'd1,
        S_F_READ  = 4'd2,
        S_DECODE  = 4'd3,
        S_O_ADDR  = 4'd4,
        S_O_READ  = 4'd5,
        S_I_ADDR  = 4'd6,
        S_I_READ  = 4'd7,
        S_D_ADDR  = 4'd8,
        S_D_READ  = 4'd9,
        S_EXEC    = 4'd10,
        S_IO_WAIT = 4'd11
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_STA = 4'h1, OP_LDA = 4'h2, OP_ADD = 4'h3,
        OP_SUB = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_NOT = 4'h7,
        OP_J   = 4'h8, OP_JN  = 4'h9, OP_JZ  = 4'hA, OP_IN  = 4'hB,
        OP_OUT = 4'hC, OP_SHR = 4'hD, OP_SHL = 4'hE, OP_HLT = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        M_DIR  = 2'b00,
        M_IND  = 2'b01,
        M_IMM  = 2'b10,
        M_DIR2 = 2'b11
    } mode_t;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    state_t            state;
    logic [DATA_W-1:0] rdm;
    logic [ADDR_W-1:0] mar;
    logic [5:0]        ri;
    opcode_t           op;
    mode_t             mode;
    opcode_t           dec_op;
    logic [DATA_W-1:0] alu_res;
    logic              upd_flags;

    // ri keeps only the opcode and mode fields; the operand lives in its own word.
    assign op     = opcode_t'(ri[5:2]);
    assign mode   = mode_t'(ri[1:0]);
    assign dec_op = opcode_t'(rdm[DATA_W-1 -: 4]);
    assign estado = state;

    function automatic logic is_load(input opcode_t o);
        return (o == OP_LDA) || (o == OP_ADD) || (o == OP_SUB) ||
               (o == OP_AND) || (o == OP_OR);
    endfunction

    function automatic logic two_word(input opcode_t o);
        return is_load(o) || (o == OP_STA) || (o == OP_J) ||
               (o == OP_JN) || (o == OP_JZ);
    endfunction

    always_comb begin
        alu_res   = ac;
        upd_flags = 1'b0;
        case (op)
            OP_LDA:  begin alu_res = rdm;                        upd_flags = 1'b1; end
            OP_ADD:  begin alu_res = ac + rdm;                   upd_flags = 1'b1; end
            OP_SUB:  begin alu_res = ac - rdm;                   upd_flags = 1'b1; end
            OP_AND:  begin alu_res = ac & rdm;                   upd_flags = 1'b1; end
            OP_OR:   begin alu_res = ac | rdm;                   upd_flags = 1'b1; end
            OP_NOT:  begin alu_res = ~ac;                        upd_flags = 1'b1; end
            OP_SHR:  begin alu_res = {1'b0, ac[DATA_W-1:1]};     upd_flags = 1'b1; end
            OP_SHL:  begin alu_res = {ac[DATA_W-2:0], 1'b0};     upd_flags = 1'b1; end
            default: ;
        endcase
    end

    // Memory is deliberately left out of reset so a program survives rst_n.
    always_ff @(posedge clk) begin
        if (state == S_HALT && load_we)
            mem[load_addr] <= load_data;
        else if (state == S_EXEC && op == OP_STA && mode != M_IMM)
            mem[rdm[ADDR_W-1:0]] <= ac;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_HALT;
            pc        <= '0;
            ac        <= '0;
            rdm       <= '0;
            mar       <= '0;
            ri        <= '0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
            saida     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            halted    <= 1'b1;
        end else begin
            case (state)
                S_HALT: begin
                    if (start) begin
                        state  <= S_F_ADDR;
                        halted <= 1'b0;
                    end
                end
                S_F_ADDR: begin
                    mar   <= pc;
                    state <= S_F_READ;
                end
                S_F_READ: begin
                    rdm   <= mem[mar];
                    pc    <= pc + ADDR_W'(1);
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    ri <= rdm[DATA_W-1 -: 6];
                    if (two_word(dec_op)) begin
                        state <= S_O_ADDR;
                    end else if (dec_op == OP_IN) begin
                        in_ready <= 1'b1;
                        state    <= S_IO_WAIT;
                    end else if (dec_op == OP_OUT) begin
                        saida     <= ac;
                        out_valid <= 1'b1;
                        state     <= S_IO_WAIT;
                    end else if (dec_op == OP_HLT) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_O_ADDR: begin
                    mar   <= pc;
                    state <= S_O_READ;
                end
                S_O_READ: begin
                    rdm <= mem[mar];
                    pc  <= pc + ADDR_W'(1);
                    if (mode == M_IND)
                        state <= S_I_ADDR;
                    else if (mode != M_IMM && is_load(op))
                        state <= S_D_ADDR;
                    else
                        state <= S_EXEC;
                end
                S_I_ADDR: begin
                    mar   <= rdm[ADDR_W-1:0];
                    state <= S_I_READ;
                end
                S_I_READ: begin
                    rdm   <= mem[mar];
                    state <= is_load(op) ? S_D_ADDR : S_EXEC;
                end
                S_D_ADDR: begin
                    mar   <= rdm[ADDR_W-1:0];
                    state <= S_D_READ;
                end
                S_D_READ: begin
                    rdm   <= mem[mar];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (upd_flags) begin
                        ac     <= alu_res;
                        flag_n <= alu_res[DATA_W-1];
                        flag_z <= (alu_res == '0);
                    end
                    if ((op == OP_J) || (op == OP_JN && flag_n) || (op == OP_JZ && flag_z))
                        pc <= rdm[ADDR_W-1:0];
                    state <= S_F_ADDR;
                end
                S_IO_WAIT: begin
                    if (op == OP_IN) begin
                        if (in_valid && in_ready) begin
                            ac       <= entrada;
                            flag_n   <= entrada[DATA_W-1];
                            flag_z   <= (entrada == '0);
                            in_ready <= 1'b0;
                            state    <= S_F_ADDR;
                        end
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_F_ADDR;
                    end
                end
                default: state <= S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_acumulador_param.sv
// Self-checking bench for cpu_acumulador_param: table of two-instruction programs
// checked through a scoreboard queue, plus hand sequences for jumps, I/O, STA, wrap and reset.
module tb_cpu_acumulador_param;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam logic [15:0] HLT = 16'hF000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          load_we;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic [DW-1:0] entrada;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] saida;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] pc;
    logic [DW-1:0] ac;
    logic          flag_n;
    logic          flag_z;
    logic          halted;
    logic [3:0]    estado;

    int vectors     = 0;
    int miscompares = 0;

    cpu_acumulador_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .entrada(entrada), .in_valid(in_valid), .in_ready(in_ready),
        .saida(saida), .out_valid(out_valid), .out_ready(out_ready),
        .pc(pc), .ac(ac), .flag_n(flag_n), .flag_z(flag_z),
        .halted(halted), .estado(estado)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ac0;
        logic [15:0] iw;
        logic [15:0] w3;
        logic [15:0] dval;
        logic [15:0] exp_ac;
        logic        exp_n;
        logic        exp_z;
        logic [7:0]  exp_pc;
        int          exp_cyc;
    } vec_t;

    vec_t tbl[14];
    vec_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [15:0] d);
        load_we = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_we = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halt(input string name, output int cyc);
        cyc = 0;
        while (!halted && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_halt"}, halted, 1);
    endtask

    task automatic wait_state(input string name, input logic [3:0] s);
        int n = 0;
        while (estado !== s && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, estado, s);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vec_t e;
        int   cyc;

        // ac0, instr, word@3, mem[0x10], exp_ac, n, z, pc, cycles(start->halted)
        tbl[0]  = '{16'h0005, 16'h3000, 16'h0010, 16'h0007, 16'h000C, 1'b0, 1'b0, 8'd5, 17};
        tbl[1]  = '{16'h8000, 16'h4800, 16'h8000, 16'h0000, 16'h0000, 1'b0, 1'b1, 8'd5, 15};
        tbl[2]  = '{16'h0003, 16'h4800, 16'h0005, 16'h0000, 16'hFFFE, 1'b1, 1'b0, 8'd5, 15};
        tbl[3]  = '{16'hFFFF, 16'h3800, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b1, 8'd5, 15};
        tbl[4]  = '{16'h0F0F, 16'h5400, 16'h0011, 16'h00FF, 16'h000F, 1'b0, 1'b0, 8'd5, 19};
        tbl[5]  = '{16'h0F0F, 16'h6000, 16'h0010, 16'hF000, 16'hFF0F, 1'b1, 1'b0, 8'd5, 17};
        tbl[6]  = '{16'h1234, 16'h2400, 16'h0011, 16'h8001, 16'h8001, 1'b1, 1'b0, 8'd5, 19};
        tbl[7]  = '{16'h5555, 16'h7000, HLT,      16'h0000, 16'hAAAA, 1'b1, 1'b0, 8'd4, 13};
        tbl[8]  = '{16'h8001, 16'hD000, HLT,      16'h0000, 16'h4000, 1'b0, 1'b0, 8'd4, 13};
        tbl[9]  = '{16'h8001, 16'hE000, HLT,      16'h0000, 16'h0002, 1'b0, 1'b0, 8'd4, 13};
        tbl[10] = '{16'h8000, 16'hE000, HLT,      16'h0000, 16'h0000, 1'b0, 1'b1, 8'd4, 13};
        tbl[11] = '{16'h8000, 16'h0000, HLT,      16'h0000, 16'h8000, 1'b1, 1'b0, 8'd4, 13};
        tbl[12] = '{16'h0001, 16'h3C00, 16'h0010, 16'h0007, 16'h0008, 1'b0, 1'b0, 8'd5, 17};
        tbl[13] = '{16'h8000, 16'h2800, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 8'd5, 15};

        rst_n = 1'b0; start = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
        entrada = '0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("rst_pc", pc, 0);
        check("rst_ac", ac, 0);
        check("rst_flags", {flag_n, flag_z}, 0);
        check("rst_halted", halted, 1);
        check("rst_estado", estado, 0);
        check("rst_io", {out_valid, in_ready}, 0);
        check("rst_saida", saida, 0);
        do_reset();

        for (int i = 0; i < 14; i++) begin
            v = tbl[i];
            do_reset();
            poke(8'h00, 16'h2800);
            poke(8'h01, v.ac0);
            poke(8'h02, v.iw);
            poke(8'h03, v.w3);
            poke(8'h04, HLT);
            poke(8'h10, v.dval);
            poke(8'h11, 16'h0010);
            sb.push_back(v);
            do_start();
            wait_halt("vec", cyc);
            e = sb.pop_front();
            check($sformatf("vec%0d_ac", i), ac, e.exp_ac);
            check($sformatf("vec%0d_n", i), flag_n, e.exp_n);
            check($sformatf("vec%0d_z", i), flag_z, e.exp_z);
            check($sformatf("vec%0d_pc", i), pc, e.exp_pc);
            check($sformatf("vec%0d_cyc", i), cyc, e.exp_cyc);
        end

        // JZ taken after 0x8000-0x8000, then JN not taken on the same flags
        do_reset();
        poke(8'h00, 16'h2800); poke(8'h01, 16'h8000);
        poke(8'h02, 16'h4800); poke(8'h03, 16'h8000);
        poke(8'h04, 16'hA000); poke(8'h05, 16'h0020);
        poke(8'h06, HLT);      poke(8'h20, HLT);
        do_start(); wait_halt("jz", cyc);
        check("jz_flags", {flag_n, flag_z}, 2'b01);
        check("jz_pc", pc, 8'h21);
        check("jz_cyc", cyc, 21);
        do_reset();
        poke(8'h04, 16'h9000);
        do_start(); wait_halt("jn_nt", cyc);
        check("jn_nt_pc", pc, 8'h07);

        // JN taken on a negative load; indirect J through mem[0x30]
        do_reset();
        poke(8'h02, 16'h9000); poke(8'h03, 16'h0020); poke(8'h04, HLT);
        do_start(); wait_halt("jn_t", cyc);
        check("jn_t_pc", pc, 8'h21);
        do_reset();
        poke(8'h00, 16'h8400); poke(8'h01, 16'h0030);
        poke(8'h30, 16'h0028); poke(8'h28, HLT);
        do_start(); wait_halt("jind", cyc);
        check("jind_pc", pc, 8'h29);
        check("jind_cyc", cyc, 11);

        // IN with a 10-cycle stall
        do_reset();
        poke(8'h00, 16'hB000); poke(8'h01, HLT);
        do_start();
        wait_state("in_wait", 4'd11);
        for (int k = 0; k < 10; k++) begin
            check("in_stall_estado", estado, 11);
            check("in_stall_ready", in_ready, 1);
            @(negedge clk);
        end
        entrada = 16'h00FF; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("in_ac", ac, 16'h00FF);
        check("in_ready_drop", in_ready, 0);
        check("in_estado", estado, 1);
        wait_halt("in", cyc);
        check("in_pc", pc, 2);

        // OUT with a 5-cycle stall; load_we/start during the stall are ignored
        do_reset();
        poke(8'h00, 16'h2800); poke(8'h01, 16'h1234);
        poke(8'h02, 16'hC000); poke(8'h03, HLT); poke(8'h04, HLT);
        do_start();
        wait_state("out_wait", 4'd11);
        load_we = 1'b1; load_addr = 8'h03; load_data = 16'h0000; start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("out_stall_valid", out_valid, 1);
            check("out_stall_saida", saida, 16'h1234);
            @(negedge clk);
        end
        load_we = 1'b0; start = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
        check("out_saida_hold", saida, 16'h1234);
        wait_halt("out", cyc);
        check("out_pc", pc, 4);

        // STA indirect writes mem[0x40]; STA immediate must not touch mem[0x41]
        do_reset();
        poke(8'h00, 16'h2800); poke(8'h01, 16'h0ABC);
        poke(8'h02, 16'h1400); poke(8'h03, 16'h0030);
        poke(8'h04, 16'h1800); poke(8'h05, 16'h0041);
        poke(8'h06, 16'h2800); poke(8'h07, 16'h0000);
        poke(8'h08, 16'h2000); poke(8'h09, 16'h0040);
        poke(8'h0A, 16'h3000); poke(8'h0B, 16'h0041);
        poke(8'h0C, HLT);
        poke(8'h30, 16'h0040); poke(8'h40, 16'h0000); poke(8'h41, 16'h1111);
        do_start(); wait_halt("sta", cyc);
        check("sta_ac", ac, 16'h1BCD);
        check("sta_pc", pc, 8'h0D);
        check("sta_cyc", cyc, 45);

        // PC wrap: halt at 0xFE, then NOP at 0xFF; mem[0] rewritten in the same cycle as start
        do_reset();
        poke(8'h00, 16'h8000); poke(8'h01, 16'h00FE); poke(8'hFE, HLT);
        do_start(); wait_halt("wrap_a", cyc);
        check("wrap_a_pc", pc, 8'hFF);
        poke(8'hFF, 16'h0000);
        load_we = 1'b1; load_addr = 8'h00; load_data = HLT; start = 1'b1;
        @(negedge clk);
        load_we = 1'b0; start = 1'b0;
        wait_halt("wrap_b", cyc);
        check("wrap_b_pc", pc, 8'h01);
        check("wrap_b_cyc", cyc, 7);

        // Asynchronous reset in the middle of an OUT handshake
        do_reset();
        poke(8'h00, 16'h2800); poke(8'h01, 16'h00AA);
        poke(8'h02, 16'hC000); poke(8'h03, HLT);
        do_start();
        wait_state("rst_out_wait", 4'd11);
        check("rst_out_valid_pre", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_estado", estado, 0);
        check("rst_mid_halted", halted, 1);
        check("rst_mid_pc_ac", {pc, ac}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start();
        wait_state("rerun_wait", 4'd11);
        check("rerun_saida", saida, 16'h00AA);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        wait_halt("rerun", cyc);
        check("rerun_pc", pc, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
